// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator core: opcodes, FSM states, default width.
package acc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: LOAD/ADD/SUB/CLEAR with signed-overflow detect.
// Define ACC_SAT_EN to clamp overflowing ADD/SUB results instead of wrapping.
module acc_alu
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] accIn,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result_c,
    output logic             ovf_c
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             addOvf;
    logic             subOvf;
    logic [WIDTH-1:0] satVal;

    // Overflow only when the operand signs allow it and the result sign flips.
    always_comb begin
        sum    = accIn + operand;
        diff   = accIn - operand;
        addOvf = (accIn[MSB] == operand[MSB]) && (sum[MSB] != accIn[MSB]);
        subOvf = (accIn[MSB] != operand[MSB]) && (diff[MSB] != accIn[MSB]);
        satVal = accIn[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_comb begin
        result_c = accIn;
        ovf_c    = 1'b0;
        case (op)
            OP_LOAD:  result_c = operand;
            OP_ADD: begin
                ovf_c = addOvf;
`ifdef ACC_SAT_EN
                result_c = addOvf ? satVal : sum;
`else
                result_c = sum;
`endif
            end
            OP_SUB: begin
                ovf_c = subOvf;
`ifdef ACC_SAT_EN
                result_c = subOvf ? satVal : diff;
`else
                result_c = diff;
`endif
            end
            OP_CLEAR: result_c = '0;
        endcase
    end

`ifndef ACC_SAT_EN
    logic unusedSat;
    assign unusedSat = ^satVal;
`endif

endmodule

// File: rtl/accumulator_core.sv
// Handshaked accumulator: IDLE accepts a command, EXEC computes, HOLD presents the result.
// Saturating arithmetic is selected with the ACC_SAT_EN macro (see acc_alu).
module accumulator_core
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InData,
    input  logic [1:0]       OP,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] AccOut,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Ovf,
    output logic             Zero
);

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [WIDTH-1:0] dataReg;
    logic [1:0]       opReg;
    logic [WIDTH-1:0] aluResult;
    logic             aluOvf;
    logic             accept;

    acc_alu #(.WIDTH(WIDTH)) uAlu (
        .accIn    (AccOut),
        .operand  (dataReg),
        .op       (opReg),
        .result_c (aluResult),
        .ovf_c    (aluOvf)
    );

    assign accept = InValid && InReady;
    assign Zero   = (AccOut == '0);

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (accept) nextState = S_EXEC;
            S_EXEC:  nextState = S_HOLD;
            S_HOLD:  if (OutReady) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // Handshake flags are registered decodes of the next state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
        end else begin
            state    <= nextState;
            InReady  <= (nextState == S_IDLE);
            OutValid <= (nextState == S_HOLD);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            dataReg <= '0;
            opReg   <= OP_LOAD;
            AccOut  <= '0;
            Ovf     <= 1'b0;
        end else begin
            if (accept) begin
                dataReg <= InData;
                opReg   <= OP;
            end
            if (state == S_EXEC) begin
                AccOut <= aluResult;
                Ovf    <= aluOvf;
            end
        end
    end

endmodule

// File: doc/accumulator_core.md
ACCUMULATOR_CORE -- requirements
Module: accumulator_core

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 InData  input  WIDTH  operand; this is the MuxOut value from the upstream operand-select mux.
REQ-005 OP  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-006 InValid  input  1  InData/OP valid this cycle.
REQ-007 InReady  output  1  core can accept a command this cycle.
REQ-008 AccOut  output  WIDTH  accumulator value.
REQ-009 OutValid  output  1  AccOut holds a new, unconsumed result.
REQ-010 OutReady  input  1  downstream consumes the result this cycle.
REQ-011 Ovf  output  1  signed overflow of the last ADD/SUB.
REQ-012 Zero  output  1  AccOut equals 0.

Function
REQ-013 A command is accepted on a rising edge where InValid and InReady are both 1.
- Commands presented while InReady is 0 are ignored.
- InValid need not be held.
REQ-014 The FSM has three states:
- IDLE: InReady=1, OutValid=0.
- EXEC: computes for one cycle; InReady=0, OutValid=0.
- HOLD: OutValid=1, InReady=0.
REQ-015 FSM transitions:
- IDLE to EXEC on an accepted command.
- EXEC to HOLD unconditionally.
- HOLD to IDLE when OutReady=1; HOLD stays in HOLD otherwise.
REQ-016 Accepted InData and OP are registered at acceptance. AccOut updates on the EXEC-to-HOLD edge.
- Latency from acceptance to OutValid=1 is 2 cycles.
REQ-017 Operations:
- LOAD: AccOut = InData.
- ADD: AccOut = AccOut + InData.
- SUB: AccOut = AccOut - InData.
- CLEAR: AccOut = 0.
- All arithmetic is two's complement, WIDTH bits.
REQ-018 Ovf rules:
- ADD/SUB: Ovf is set when the operand signs make the signed result unrepresentable.
- LOAD/CLEAR: Ovf is cleared.
- Ovf updates on the same edge as AccOut.
REQ-019 Without the saturation option, overflowing results wrap modulo 2^WIDTH.
REQ-020 Zero is combinational from AccOut.
REQ-021 AccOut and Ovf hold their values in IDLE and HOLD.
REQ-022 If OutReady=1 in HOLD while InValid=1, the command is not accepted that cycle. It is accepted the next cycle, in IDLE.
REQ-023 OutReady is ignored outside HOLD.

Reset
REQ-024 Asserting Reset forces these values immediately, regardless of CLK:
- state IDLE, AccOut=0, Ovf=0, OutValid=0, InReady=1 and Zero=1.
REQ-025 Reset asserted in EXEC or HOLD discards the in-flight command with no result delivered.
- After Reset is released, the next rising edge may accept a command.

Configuration
REQ-026 Macro ACC_SAT_EN.
- Defined: an overflowing ADD/SUB saturates to the maximum positive value (0x7FFF at WIDTH=16) or the minimum negative value (0x8000); Ovf is still set.
- Undefined: overflowing results wrap as in REQ-019.

Structure
REQ-027 Shared package acc_pkg holds:
- the OP encodings (OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR);
- the FSM state encodings (S_IDLE, S_EXEC, S_HOLD);
- DEFAULT_WIDTH=16.
REQ-028 One sub-module, acc_alu, is combinational. It takes the accumulator value, operand and OP, and returns the result and overflow, including the saturation logic.
REQ-029 The FSM and registers reside in accumulator_core.

Verification
REQ-030 Reset mid-EXEC: Reset during EXEC -> AccOut=0, OutValid=0, InReady=1, Zero=1; no result appears.
REQ-031 LOAD then ADD:
- LOAD 0x0008, handshake -> AccOut=0x0008.
- ADD 0x0004 -> AccOut=0x000C, Ovf=0, OutValid=1 two cycles after acceptance.
REQ-032 Backpressure: OutReady=0 for 5 cycles in HOLD -> OutValid=1, AccOut stable, InReady=0; commands offered meanwhile are ignored.
REQ-033 Signed overflow: LOAD 0x7FFF, then ADD 0x0001 -> Ovf=1.
- Macro undefined: AccOut=0x8000.
- ACC_SAT_EN defined: AccOut=0x7FFF.
REQ-034 SUB to zero: LOAD 0x0005, then SUB 0x0005 -> AccOut=0, Zero=1, Ovf=0.
- CLEAR after an overflow -> Ovf=0.
REQ-035 Back-to-back: OutReady and InValid held high -> a command is accepted every 3 cycles, and no result is dropped or duplicated.
